// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_counter
//  Brief    : Tenth-of-a-second stopwatch, 0:00.0 .. 9:59.9, with run/stop,
//             lap freeze and clear, four BCD nibbles for 7-segment decoders.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
  parameter int TICK_DIV = 10000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int              c_PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(TICK_DIV - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RUNNING = 2'd1;
  localparam logic [1:0] c_STOPPED = 2'd2;
  localparam logic [1:0] c_LAP     = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [c_PW-1:0] r_pre;
  logic [3:0]      r_min;
  logic [3:0]      r_sec10;
  logic [3:0]      r_sec1;
  logic [3:0]      r_tenth;
  logic [15:0]     r_lap;
  logic            r_overflow;

  logic [15:0]     w_live;
  logic            w_active;
  logic            w_tick;
  logic            w_clear_go;
  logic            w_lap_capture;

  assign w_live        = {r_min, r_sec10, r_sec1, r_tenth};
  assign w_active      = (r_state == c_RUNNING) || (r_state == c_LAP);
  assign w_tick        = w_active && (r_pre == c_PRE_MAX);
  // clear only acts from STOPPED, where it also outranks start_stop
  assign w_clear_go    = (r_state == c_STOPPED) && clear;
  // lap loses to a simultaneous start_stop
  assign w_lap_capture = (r_state == c_RUNNING) && lap && !start_stop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; pulses that do not apply in a state fall through
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (start_stop) w_next_state = c_RUNNING;
      end
      c_RUNNING: begin
        if (start_stop)  w_next_state = c_STOPPED;
        else if (lap)    w_next_state = c_LAP;
      end
      c_LAP: begin
        if (start_stop)  w_next_state = c_STOPPED;
        else if (lap)    w_next_state = c_RUNNING;
      end
      c_STOPPED: begin
        if (clear)           w_next_state = c_IDLE;
        else if (start_stop) w_next_state = c_RUNNING;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output decode: lap register is shown only while frozen in LAP
  always_comb begin
    running    = w_active;
    lap_active = (r_state == c_LAP);
    digits     = (r_state == c_LAP) ? r_lap : w_live;
    overflow   = r_overflow;
  end

  // Prescaler: runs while counting, holds when stopped, zeroed by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_clear_go) begin
      r_pre <= '0;
    end else if (w_active) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end

  // Live BCD count, advancing one tenth per tick with ripple carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min   <= 4'd0;
      r_sec10 <= 4'd0;
      r_sec1  <= 4'd0;
      r_tenth <= 4'd0;
    end else if (w_clear_go) begin
      r_min   <= 4'd0;
      r_sec10 <= 4'd0;
      r_sec1  <= 4'd0;
      r_tenth <= 4'd0;
    end else if (w_tick) begin
      if (r_tenth != 4'd9) begin
        r_tenth <= r_tenth + 4'd1;
      end else begin
        r_tenth <= 4'd0;
        if (r_sec1 != 4'd9) begin
          r_sec1 <= r_sec1 + 4'd1;
        end else begin
          r_sec1 <= 4'd0;
          if (r_sec10 != 4'd5) begin
            r_sec10 <= r_sec10 + 4'd1;
          end else begin
            r_sec10 <= 4'd0;
            r_min   <= (r_min == 4'd9) ? 4'd0 : r_min + 4'd1;
          end
        end
      end
    end
  end

  // Lap register snapshots the value on display as LAP is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap <= 16'h0000;
    end else if (w_clear_go) begin
      r_lap <= 16'h0000;
    end else if (w_lap_capture) begin
      r_lap <= w_live;
    end
  end

  // Single-cycle overflow flag when the count rolls past 9:59.9
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_tick && (w_live == 16'h9599);
    end
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10000000, clock cycles per 0.1 s tick (100 MHz clk); legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_stop  input  1  one-cycle pulse, already debounced and synchronous to clk; toggles run/stop.
REQ-005 SHALL have port lap  input  1  one-cycle pulse; freezes or releases the displayed value.
REQ-006 SHALL have port clear  input  1  one-cycle pulse; zeroes the time when the watch is not counting.
REQ-007 SHALL have port digits  output  16  displayed time as four BCD nibbles: [15:12] minutes 0-9, [11:8] seconds tens 0-5, [7:4] seconds ones 0-9, [3:0] tenths 0-9; each nibble drives one sevensegment decoder ABCD input.
REQ-008 SHALL have port running  output  1  high in RUNNING or LAP.
REQ-009 SHALL have port lap_active  output  1  high in LAP.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse on wrap from 9:59.9 to 0:00.0.

Function
REQ-011 SHALL implement FSM states IDLE, RUNNING, STOPPED, LAP.
REQ-012 Transitions SHALL be: IDLE+start_stop->RUNNING; RUNNING+start_stop->STOPPED; STOPPED+start_stop->RUNNING; RUNNING+lap->LAP; LAP+lap->RUNNING; LAP+start_stop->STOPPED; STOPPED+clear->IDLE.
REQ-013 lap in IDLE or STOPPED, and clear in RUNNING or LAP, SHALL be ignored without side effects.
REQ-014 Priority on simultaneous pulses SHALL be clear > start_stop > lap; only the winning pulse acts that cycle.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only in RUNNING or LAP, hold its value in STOPPED, and be zero in IDLE.
REQ-016 A tick SHALL occur on the edge where the prescaler wraps from TICK_DIV-1 to 0; the live count advances by 0.1 s on that same edge.
REQ-017 The live count SHALL carry in BCD: tenths 9->0 increments seconds ones; ones 9->0 increments tens; tens 5->0 increments minutes; no nibble ever holds a value outside its range.
REQ-018 At 9:59.9, a tick SHALL wrap the live count to 0:00.0, assert overflow for exactly that one cycle, and keep the state unchanged.
REQ-019 Entering LAP SHALL copy the live count into a lap register on the same edge; the live count continues advancing.
REQ-020 digits SHALL show the lap register in LAP and the live count in all other states; the update is visible the cycle after the triggering edge.
REQ-021 On LAP->STOPPED, digits SHALL switch to the frozen live count.
REQ-022 clear SHALL zero the live count, the lap register and the prescaler on the transition to IDLE.
REQ-023 A start_stop that coincides with a tick SHALL let the tick take effect before stopping.

Reset
REQ-024 While rst_n is low, the block SHALL immediately force state IDLE, prescaler 0, live count and lap register 0, digits 16'h0000, and running, lap_active and overflow 0, regardless of clk.
REQ-025 Deassertion of rst_n SHALL take effect at the next rising clk edge; reset during RUNNING or LAP discards all progress.

Verification (TICK_DIV=4)
REQ-026 Reset: assert rst_n low mid-count at digits 16'h0123 -> digits 16'h0000 and running=0 before the next clk edge.
REQ-027 Count: start_stop, then 40 cycles -> digits 16'h0010, running=1; further runs show 0:09.9->16'h0100 and 0:59.9->16'h1000.
REQ-028 Wrap: run to 16'h9599, one more tick -> 16'h0000, overflow high for exactly 1 cycle, running stays 1.
REQ-029 Lap: lap at 16'h0005, wait 12 cycles -> digits stay 16'h0005 and lap_active=1; lap again -> digits 16'h0008.
REQ-030 Stop/clear: stop at 16'h0007 and wait 20 cycles -> digits hold 16'h0007; clear while RUNNING is ignored; clear+start_stop in the same cycle while STOPPED -> IDLE with 16'h0000; restart gives first tick exactly 4 cycles later.
